// File: rtl/cond_pkg.sv
// Shared definitions for the sequential condition unit: opcode values,
// FSM state encoding and the final condition derivation.
// Optional feature macro: COND_SIGNED_EN (enables signed opcodes 8-B).
package cond_pkg;

  localparam logic [3:0] COND_EQ    = 4'h0;
  localparam logic [3:0] COND_NE    = 4'h1;
  localparam logic [3:0] COND_LTU   = 4'h2;
  localparam logic [3:0] COND_LEU   = 4'h3;
  localparam logic [3:0] COND_GTU   = 4'h4;
  localparam logic [3:0] COND_GEU   = 4'h5;
  localparam logic [3:0] COND_FALSE = 4'h6;
  localparam logic [3:0] COND_TRUE  = 4'h7;
  localparam logic [3:0] COND_LTS   = 4'h8;
  localparam logic [3:0] COND_LES   = 4'h9;
  localparam logic [3:0] COND_GTS   = 4'hA;
  localparam logic [3:0] COND_GES   = 4'hB;

  typedef enum logic [1:0] {
    COND_IDLE = 2'd0,
    COND_ACC  = 2'd1,
    COND_DONE = 2'd2
  } cond_state_e;

  // Turns the accumulated equal/less-than pair into {err, result}.
  // Opcodes that are not evaluated in this build report an error with result 0.
  function automatic logic [1:0] cond_eval(input logic [3:0] op,
                                           input logic       eq,
                                           input logic       lt);
    logic [1:0] r;
    r = 2'b10;
    case (op)
      COND_EQ:    r = {1'b0, eq};
      COND_NE:    r = {1'b0, !eq};
      COND_LTU:   r = {1'b0, lt};
      COND_LEU:   r = {1'b0, lt | eq};
      COND_GTU:   r = {1'b0, !lt & !eq};
      COND_GEU:   r = {1'b0, !lt};
      COND_FALSE: r = 2'b00;
      COND_TRUE:  r = 2'b01;
`ifdef COND_SIGNED_EN
      COND_LTS:   r = {1'b0, lt};
      COND_LES:   r = {1'b0, lt | eq};
      COND_GTS:   r = {1'b0, !lt & !eq};
      COND_GES:   r = {1'b0, !lt};
`endif
      default:    r = 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_beat_cmp.sv
// Per-word comparator: equality, unsigned less-than and, when COND_SIGNED_EN
// is defined, two's-complement less-than for the most-significant word.
module cond_beat_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             ltu
`ifdef COND_SIGNED_EN
  ,
  output logic             lts
`endif
);

  assign eq  = (a == b);
  assign ltu = (a < b);

`ifdef COND_SIGNED_EN
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  assign a_s = a;
  assign b_s = b;
  assign lts = (a_s < b_s);
`endif

endmodule

// File: rtl/cond_seq.sv
// Multi-beat condition unit: compares operands streamed least-significant
// word first, reports the outcome with a valid/ready handshake and keeps a
// sticky condition flag for branch logic.
// Optional feature macro: COND_SIGNED_EN (signed opcodes 8-B).
module cond_seq
  import cond_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             first,
  input  logic             last,
  input  logic [WIDTH-1:0] para_a,
  input  logic [WIDTH-1:0] para_b,
  input  logic [7:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             err,
  input  logic             en,
  output logic             data_o
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  cond_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic [3:0]    op_q, op_d;
  logic          res_q, res_d;
  logic          err_q, err_d;
  logic          flag_q, flag_d;

  logic          eq_w, ltu_w, word_lt, eq_n, lt_n, accept;
  logic [3:0]    op_eff;
  logic [1:0]    eval_w;
  logic          unused_opcode_hi;

  assign unused_opcode_hi = ^opcode[7:4];

`ifdef COND_SIGNED_EN
  logic lts_w;
  cond_beat_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a(para_a), .b(para_b), .eq(eq_w), .ltu(ltu_w), .lts(lts_w)
  );
`else
  cond_beat_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a(para_a), .b(para_b), .eq(eq_w), .ltu(ltu_w)
  );
`endif

  // Word-level less-than: signed only for the top word of a signed compare.
  always_comb begin
    op_eff  = first ? opcode[3:0] : op_q;
    word_lt = ltu_w;
`ifdef COND_SIGNED_EN
    if (last && op_eff[3] && !op_eff[2]) word_lt = lts_w;
`endif
    if (first) begin
      eq_n = eq_w;
      lt_n = word_lt;
    end else begin
      eq_n = eq_q & eq_w;
      lt_n = eq_w ? lt_q : word_lt;
    end
    eval_w = cond_eval(op_eff, eq_n, lt_n);
  end

  // FSM next state, accumulator/counter updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    op_d      = op_q;
    res_d     = res_q;
    err_d     = err_q;
    flag_d    = flag_q;
    in_ready  = rst && (state_q != COND_DONE);
    out_valid = (state_q == COND_DONE);
    accept    = in_valid && in_ready;

    if (state_q == COND_DONE) begin
      if (out_ready) begin
        state_d = COND_IDLE;
        cnt_d   = '0;
      end
    end else if (accept && (first || state_q == COND_ACC)) begin
      if (!first && !last && cnt_q == CNT_MAX) begin
        // Too many beats: close the compare as an error.
        state_d = COND_DONE;
        res_d   = 1'b0;
        err_d   = 1'b1;
        flag_d  = 1'b0;
      end else begin
        eq_d  = eq_n;
        lt_d  = lt_n;
        op_d  = op_eff;
        cnt_d = first ? CNT_ONE : cnt_q + CNT_ONE;
        if (last) begin
          state_d = COND_DONE;
          res_d   = eval_w[0];
          err_d   = eval_w[1];
          flag_d  = eval_w[0];
        end else begin
          state_d = COND_ACC;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COND_IDLE;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      op_q    <= '0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
    end
  end

  assign result = res_q;
  assign err    = err_q;
  assign data_o = en ? flag_q : 1'b0;

endmodule

// File: tb/tb_cond_seq.sv
// Self-checking bench for cond_seq: fixed vectors, multi-cycle corner
// sequences and randomized compares against a numeric reference model.
module tb_cond_seq;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
`ifdef COND_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             first = 1'b0;
  logic             last = 1'b0;
  logic [WIDTH-1:0] para_a = '0;
  logic [WIDTH-1:0] para_b = '0;
  logic [7:0]       opcode = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             result;
  logic             err;
  logic             en = 1'b0;
  logic             data_o;

  int checks = 0;
  int errors = 0;

  cond_seq #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .first(first), .last(last), .para_a(para_a), .para_b(para_b),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .en(en), .data_o(data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic        res;
    logic        er;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Reference: whole-operand numeric compare, {err, result}.
  function automatic logic [1:0] ref_cmp(input int op, input longint a,
                                         input longint b, input int n);
    longint one, sa, sb;
    int     bits;
    bit     sgn, lt, eq, r;
    one  = 1;
    bits = n * WIDTH;
    sa = a; sb = b;
    if (a >= (one << (bits - 1))) sa = a - (one << bits);
    if (b >= (one << (bits - 1))) sb = b - (one << bits);
    sgn = (op >= 8 && op <= 11);
    if (op >= 12 || (sgn && !SIGNED_EN)) return 2'b10;
    eq = (a == b);
    lt = sgn ? (sa < sb) : (a < b);
    case (op % 4)
      0: r = (op == 0) ? eq : (op == 4) ? (!lt && !eq) : lt;
      1: r = (op == 1) ? !eq : (op == 5) ? !lt : (lt || eq);
      2: r = (op == 2) ? lt : (op == 6) ? 1'b0 : (!lt && !eq);
      default: r = (op == 3) ? (lt || eq) : (op == 7) ? 1'b1 : !lt;
    endcase
    return {1'b0, r};
  endfunction

  task automatic drive_beat(input logic f, input logic l, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [3:0] op);
    in_valid = 1'b1; first = f; last = l;
    para_a = a; para_b = b; opcode = {4'hE, op};
    @(posedge clk); #1;
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_drained"}, out_valid, 1'b0);
  endtask

  task automatic do_compare(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int n, input logic er_res,
                            input logic er_err, input logic en_v);
    for (int i = 0; i < n; i++)
      drive_beat(i == 0, i == n - 1, a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH], op);
    en = en_v;
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_result"}, result, er_res);
    check({name, "_err"}, err, er_err);
    check({name, "_data_o"}, data_o, en_v & er_res);
    drain(name);
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'h2, 32'h03,       32'h05,       1, 1'b1, 1'b0};
    vecs[1]  = '{4'h4, 32'h0100,     32'h00FF,     2, 1'b1, 1'b0};
    vecs[2]  = '{4'h0, 32'h0100,     32'h00FF,     2, 1'b0, 1'b0};
    vecs[3]  = '{4'hC, 32'h01,       32'h01,       1, 1'b0, 1'b1};
    vecs[4]  = '{4'h6, 32'h01,       32'h01,       1, 1'b0, 1'b0};
    vecs[5]  = '{4'h7, 32'h01,       32'h02,       1, 1'b1, 1'b0};
    vecs[6]  = '{4'h3, 32'h1234,     32'h1234,     2, 1'b1, 1'b0};
    vecs[7]  = '{4'h5, 32'h00000001, 32'h01000000, 4, 1'b0, 1'b0};
    vecs[8]  = '{4'h1, 32'h123456,   32'h123457,   3, 1'b1, 1'b0};
`ifdef COND_SIGNED_EN
    vecs[9]  = '{4'h8, 32'h80,       32'h01,       1, 1'b1, 1'b0};
    vecs[10] = '{4'hB, 32'hFF00,     32'h0001,     2, 1'b0, 1'b0};
    vecs[11] = '{4'hA, 32'h01,       32'hFF,       1, 1'b1, 1'b0};
`else
    vecs[9]  = '{4'h8, 32'h80,       32'h01,       1, 1'b0, 1'b1};
    vecs[10] = '{4'hB, 32'hFF00,     32'h0001,     2, 1'b0, 1'b1};
    vecs[11] = '{4'hA, 32'h01,       32'hFF,       1, 1'b0, 1'b1};
`endif

    // Reset state
    rst = 1'b0; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data_o", data_o, 1'b0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Vector table
    foreach (vecs[i])
      do_compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].n, vecs[i].res, vecs[i].er, 1'b1);

    // en gates data_o combinationally (flag holds LTU true)
    do_compare("ltu_en", 4'h2, 32'h03, 32'h05, 1, 1'b1, 1'b0, 1'b1);
    en = 1'b0; #1;
    check("en0_data_o", data_o, 1'b0);
    en = 1'b1; #1;
    check("en1_data_o", data_o, 1'b1);

    // Overflow: five beats, no last
    for (int i = 0; i < 4; i++) drive_beat(i == 0, 1'b0, 8'h11, 8'h11, 4'h7);
    check("ovf_4beats_no_valid", out_valid, 1'b0);
    drive_beat(1'b0, 1'b0, 8'h11, 8'h11, 4'h7);
    @(negedge clk);
    check("ovf_valid", out_valid, 1'b1);
    check("ovf_result", result, 1'b0);
    check("ovf_err", err, 1'b1);
    check("ovf_flag", data_o, 1'b0);
    drain("ovf");

    // Backpressure after TRUE
    drive_beat(1'b1, 1'b1, 8'h00, 8'h00, 4'h7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), out_valid, 1'b1);
      check($sformatf("bp%0d_result", i), result, 1'b1);
      check($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_flag_set", data_o, 1'b1);

    // Reset mid-ACC
    drive_beat(1'b1, 1'b0, 8'h01, 8'h01, 4'h7);
    rst = 1'b0;
    #1;
    check("rstacc_in_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstacc_valid", out_valid, 1'b0);
    check("rstacc_flag", data_o, 1'b0);
    drive_beat(1'b0, 1'b1, 8'h01, 8'h01, 4'h7);
    @(negedge clk);
    check("rstacc_dropped", out_valid, 1'b0);

    // Abort: a new first beat in ACC restarts with the new opcode
    drive_beat(1'b1, 1'b0, 8'h01, 8'h02, 4'h0);
    drive_beat(1'b1, 1'b1, 8'h01, 8'h02, 4'h2);
    @(negedge clk);
    check("abort_valid", out_valid, 1'b1);
    check("abort_result", result, 1'b1);
    drain("abort");

    // Randomized compares against the reference model
    for (int t = 0; t < 200; t++) begin
      int          n, op, mode;
      logic [31:0] a, b, mask;
      logic [1:0]  exp;
      n    = $urandom_range(1, MAX_BEATS);
      op   = $urandom_range(0, 15);
      mask = (n == 4) ? 32'hFFFFFFFF : ((32'h1 << (n * WIDTH)) - 1);
      a    = $urandom & mask;
      mode = $urandom_range(0, 3);
      if (mode == 0)      b = a;
      else if (mode == 1) b = a ^ (32'h1 << $urandom_range(0, WIDTH - 1));
      else if (mode == 2) b = a ^ (32'h80 << ((n - 1) * WIDTH));
      else                b = $urandom & mask;
      exp = ref_cmp(op, longint'(a), longint'(b), n);
      do_compare($sformatf("rnd%0d", t), op[3:0], a, b, n, exp[0], exp[1],
                 logic'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
